// File: rtl/streaming_ring_pkg.sv
// Shared types and helpers for streaming_ring_collector: slot type, lane-index
// width and the round-robin grant search.
package streaming_ring_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 9;
  localparam int MAX_LANES          = 8;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] slot_t;

  // Width of a lane index; never 0 so a single-lane build still has a signal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First ready lane after `last`, searched cyclically. Before any grant has been
  // made the search starts at lane 0 itself, so the very first grant goes to lane 0.
  function automatic int rr_next_grant(input logic [MAX_LANES-1:0] ready,
                                       input int                   last,
                                       input logic                 has_last,
                                       input int                   num_lanes);
    int   grant;
    int   idx;
    logic found;
    grant = last;
    found = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      idx = (last + i + (has_last ? 1 : 0)) % num_lanes;
      if (i < num_lanes && !found && ready[idx[2:0]]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/ring_input_fifo.sv
// Single-clock register FIFO with show-ahead head and free-entry count.
// Pushes while full and pops while empty are ignored.
module ring_input_fifo import streaming_ring_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_free_count
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CAPACITY = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CAPACITY);
  assign o_free_count = CAPACITY - r_count;
  assign o_head       = r_mem[r_rd_ptr];
  assign w_push_ok    = i_push & ~o_full;
  assign w_pop_ok     = i_pop & ~o_empty;

  // NOTE: storage arrays carry no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/streaming_ring_collector.sv
// Tags input beats with a ring slot, dispatches round-robin to compute lanes and
// re-emits lane results in input order DEPTH cycles later.
// Optional late-result detection: STREAMING_RING_LATE_DETECT_EN.
module streaming_ring_collector import streaming_ring_pkg::*; #(
  parameter int DATA_WIDTH         = 128,
  parameter int RESULT_WIDTH       = 6,
  parameter int EXTRA_DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
  parameter int NUM_LANES          = 2,
  parameter int FIFO_DEPTH_LOG2    = 5,
  parameter int ALMOST_FULL_MARGIN = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              isBotValid,
  input  logic [DATA_WIDTH-1:0]             graphIn,
  input  logic [EXTRA_DATA_WIDTH-1:0]       extraDataIn,
  output logic                              slowDownInput,
  input  logic [NUM_LANES-1:0]              laneReady,
  output logic [NUM_LANES-1:0]              laneValid,
  output logic [DATA_WIDTH-1:0]             laneData,
  output logic [ADDR_WIDTH-1:0]             laneSlot,
  input  logic [NUM_LANES-1:0]              laneDone,
  input  logic [NUM_LANES*RESULT_WIDTH-1:0] laneResult,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   laneResultSlot,
  output logic                              resultValid,
  output logic [RESULT_WIDTH-1:0]           result,
  output logic [EXTRA_DATA_WIDTH-1:0]       extraDataOut,
  output logic                              errorStatus
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LW    = clog2_min1(NUM_LANES);
  localparam int FW    = DATA_WIDTH + ADDR_WIDTH;
  localparam int FL    = FIFO_DEPTH_LOG2;
  localparam logic [FL:0] MARGIN = (FL+1)'(ALMOST_FULL_MARGIN);

  logic [ADDR_WIDTH-1:0]       r_slot_idx;
  logic [DEPTH-1:0]            r_valid_mem;
  logic [EXTRA_DATA_WIDTH-1:0] r_extra_mem [DEPTH];
  logic [RESULT_WIDTH-1:0]     r_result_mem [DEPTH];
  logic [LW-1:0]               r_last_grant;
  logic                        r_has_grant;

  logic [FW-1:0]               w_head;
  logic                        w_empty;
  logic                        w_full;
  logic [FL:0]                 w_free;
  logic [FL:0]                 w_free_next;
  logic                        w_push_ok;
  logic                        w_overflow;
  logic                        w_pop;
  logic [LW-1:0]               w_grant;
  logic [NUM_LANES-1:0]        w_grant_onehot;
  logic [ADDR_WIDTH-1:0]       w_done_slot [NUM_LANES];
  logic [RESULT_WIDTH-1:0]     w_done_res  [NUM_LANES];
  logic                        w_collision;
  logic                        w_late;

  ring_input_fifo #(.WIDTH(FW), .DEPTH_LOG2(FL)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (isBotValid),
    .i_push_data  ({graphIn, r_slot_idx}),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_free_count (w_free)
  );

  assign w_push_ok   = isBotValid & ~w_full;
  assign w_overflow  = isBotValid & w_full;
  assign w_pop       = ~w_empty & (|laneReady);
  assign w_free_next = w_free - (FL+1)'(w_push_ok) + (FL+1)'(w_pop);
  assign w_grant     = LW'(rr_next_grant(MAX_LANES'(laneReady), int'(r_last_grant),
                                         r_has_grant, NUM_LANES));

  always_comb begin
    w_grant_onehot          = '0;
    w_grant_onehot[w_grant] = 1'b1;
  end

  always_comb begin
    w_collision = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_done_slot[l] = laneResultSlot[l*ADDR_WIDTH +: ADDR_WIDTH];
      w_done_res[l]  = laneResult[l*RESULT_WIDTH +: RESULT_WIDTH];
    end
    for (int l = 0; l < NUM_LANES; l++)
      for (int m = l + 1; m < NUM_LANES; m++)
        if (laneDone[l] && laneDone[m] && (w_done_slot[l] == w_done_slot[m]))
          w_collision = 1'b1;
  end

`ifdef STREAMING_RING_LATE_DETECT_EN
  logic [DEPTH-1:0] r_pending;

  // The accept is scheduled after the lane clears, so a same-slot collision keeps pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (laneDone[l]) r_pending[w_done_slot[l]] <= 1'b0;
      if (isBotValid) r_pending[r_slot_idx] <= 1'b1;
    end
  end

  assign w_late = r_valid_mem[r_slot_idx] & r_pending[r_slot_idx];
`else
  assign w_late = 1'b0;
`endif

  // NOTE: with non-blocking writes the last loop iteration wins, giving the highest lane priority.
  always_ff @(posedge clk) begin
    r_extra_mem[r_slot_idx] <= extraDataIn;
    for (int l = 0; l < NUM_LANES; l++)
      if (laneDone[l]) r_result_mem[w_done_slot[l]] <= w_done_res[l];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_idx    <= '0;
      r_valid_mem   <= '0;
      r_last_grant  <= '0;
      r_has_grant   <= 1'b0;
      laneValid     <= '0;
      laneData      <= '0;
      laneSlot      <= '0;
      resultValid   <= 1'b0;
      result        <= '0;
      extraDataOut  <= '0;
      errorStatus   <= 1'b0;
      slowDownInput <= 1'b0;
    end else begin
      r_slot_idx              <= r_slot_idx + ADDR_WIDTH'(1);
      r_valid_mem[r_slot_idx] <= isBotValid;
      resultValid             <= r_valid_mem[r_slot_idx];
      result                  <= r_result_mem[r_slot_idx];
      extraDataOut            <= r_extra_mem[r_slot_idx];
      errorStatus             <= w_overflow | w_collision | w_late;
      slowDownInput           <= (w_free_next < MARGIN);
      laneValid               <= w_pop ? w_grant_onehot : '0;
      if (w_pop) begin
        laneData     <= w_head[FW-1:ADDR_WIDTH];
        laneSlot     <= w_head[ADDR_WIDTH-1:0];
        r_last_grant <= w_grant;
        r_has_grant  <= 1'b1;
      end
    end
  end

endmodule
